// File: rtl/audio_pkg.sv
// audio_pkg: shared FSM states, default sample width and saturation helper for the audio mixer
package audio_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_OUT} state_e;
  localparam int AUDIO_DW_DEF = 16;
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int dw);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction
endpackage

// File: rtl/audio_rate_gen.sv
// audio_rate_gen: fractional-accumulator tick generator producing RATE ticks per second from clk_rate
module audio_rate_gen #(
  parameter int RATE = 48_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] clk_rate,
  output logic        tick
);
  logic [31:0] acc_q, acc_d;
  logic        tick_q, tick_d;
  logic [32:0] acc_next;
  logic        wrap;
  // advance the phase accumulator, wrapping by clk_rate; a zero rate never ticks
  always_comb begin
    acc_next = {1'b0, acc_q} + 33'(RATE);
    wrap     = acc_next >= {1'b0, clk_rate};
    acc_d    = wrap ? 32'(acc_next - {1'b0, clk_rate}) : acc_next[31:0];
    tick_d   = wrap && clk_rate != '0;
  end
  // accumulator and registered tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end
  assign tick = tick_q;
endmodule

// File: rtl/audio_src_mixer.sv
// audio_src_mixer: per-frame source poller and stereo mixer; AUDIO_MIX_SAT_EN selects saturating unity-gain mix over shifted mix
module audio_src_mixer
  import audio_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int AUDIO_DW = AUDIO_DW_DEF,
  parameter int I2S_Freq = 48_000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [31:0]                  clk_rate,
  input  logic [NUM_SRC-1:0]           src_en,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic [NUM_SRC*AUDIO_DW-1:0]  src_left,
  input  logic [NUM_SRC*AUDIO_DW-1:0]  src_right,
  output logic [AUDIO_DW-1:0]          left_chan,
  output logic [AUDIO_DW-1:0]          right_chan,
  output logic                         sample_stb,
  output logic [NUM_SRC-1:0]           underrun,
  input  logic                         underrun_clr
);
  localparam int LG = $clog2(NUM_SRC);
  localparam int SW = AUDIO_DW + LG;
  state_e                     state_q, state_d;
  logic                       pend_q, pend_d;
  logic [LG-1:0]              idx_q, idx_d;
  logic signed [SW-1:0]       sum_l_q, sum_l_d, sum_r_q, sum_r_d;
  logic signed [AUDIO_DW-1:0] hold_l_q [NUM_SRC];
  logic signed [AUDIO_DW-1:0] hold_l_d [NUM_SRC];
  logic signed [AUDIO_DW-1:0] hold_r_q [NUM_SRC];
  logic signed [AUDIO_DW-1:0] hold_r_d [NUM_SRC];
  logic [AUDIO_DW-1:0]        left_q, left_d, right_q, right_d;
  logic                       stb_q, stb_d;
  logic [NUM_SRC-1:0]         ur_q, ur_d;
  logic                       tick, cur_en, cur_v;
  logic signed [AUDIO_DW-1:0] new_l, new_r, add_l, add_r;

  audio_rate_gen #(.RATE(I2S_Freq)) u_rate (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_rate (clk_rate),
    .tick     (tick)
  );

  // frame FSM: start on tick/pend, scan one source per cycle into the shared adder, then publish
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q | (tick && state_q != ST_IDLE);
    idx_d     = idx_q;
    sum_l_d   = sum_l_q;
    sum_r_d   = sum_r_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    left_d    = left_q;
    right_d   = right_q;
    stb_d     = 1'b0;
    ur_d      = ur_q;
    src_ready = '0;
    cur_en    = src_en[idx_q];
    cur_v     = src_valid[idx_q];
    new_l     = src_left[idx_q * AUDIO_DW +: AUDIO_DW];
    new_r     = src_right[idx_q * AUDIO_DW +: AUDIO_DW];
    add_l     = !cur_en ? '0 : (cur_v ? new_l : hold_l_q[idx_q]);
    add_r     = !cur_en ? '0 : (cur_v ? new_r : hold_r_q[idx_q]);
    if (state_q == ST_IDLE) begin
      if (tick || pend_q) begin
        state_d = ST_SCAN;
        pend_d  = 1'b0;
        idx_d   = '0;
        sum_l_d = '0;
        sum_r_d = '0;
      end
    end else if (state_q == ST_SCAN) begin
      src_ready[idx_q] = cur_en && cur_v;
      sum_l_d = sum_l_q + SW'(add_l);
      sum_r_d = sum_r_q + SW'(add_r);
      if (cur_en && cur_v) begin
        hold_l_d[idx_q] = new_l;
        hold_r_d[idx_q] = new_r;
      end
      if (cur_en && !cur_v) ur_d[idx_q] = 1'b1;
      idx_d = idx_q + 1'b1;
      if (idx_q == LG'(NUM_SRC - 1)) state_d = ST_OUT;
    end else begin
`ifdef AUDIO_MIX_SAT_EN
      left_d  = AUDIO_DW'(sat(32'(sum_l_q), AUDIO_DW));
      right_d = AUDIO_DW'(sat(32'(sum_r_q), AUDIO_DW));
`else
      left_d  = AUDIO_DW'(sum_l_q >>> LG);
      right_d = AUDIO_DW'(sum_r_q >>> LG);
`endif
      stb_d   = 1'b1;
      state_d = ST_IDLE;
    end
    if (underrun_clr) ur_d = '0;
  end

  // state, sums, per-source hold registers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      idx_q   <= '0;
      sum_l_q <= '0;
      sum_r_q <= '0;
      left_q  <= '0;
      right_q <= '0;
      stb_q   <= 1'b0;
      ur_q    <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        hold_l_q[i] <= '0;
        hold_r_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      idx_q    <= idx_d;
      sum_l_q  <= sum_l_d;
      sum_r_q  <= sum_r_d;
      left_q   <= left_d;
      right_q  <= right_d;
      stb_q    <= stb_d;
      ur_q     <= ur_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
    end
  end

  assign left_chan  = left_q;
  assign right_chan = right_q;
  assign sample_stb = stb_q;
  assign underrun   = ur_q;
endmodule

// File: tb/tb_audio_src_mixer.sv
// tb_audio_src_mixer: randomized frame-level checks of audio_src_mixer against a per-frame mixing model
module tb_audio_src_mixer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] clk_rate;
  logic [3:0]  src_en, src_valid, src_ready, underrun;
  logic [63:0] src_left, src_right;
  logic [15:0] left_chan, right_chan;
  logic        sample_stb, underrun_clr;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          rdy_cnt [4];
  int          mh_l [4];
  int          mh_r [4];
  logic [3:0]  exp_ur;

  audio_src_mixer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clk_rate     (clk_rate),
    .src_en       (src_en),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_left     (src_left),
    .src_right    (src_right),
    .left_chan    (left_chan),
    .right_chan   (right_chan),
    .sample_stb   (sample_stb),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mix(input int s);
    int q;
`ifdef AUDIO_MIX_SAT_EN
    q = s > 32767 ? 32767 : (s < -32768 ? -32768 : s);
`else
    q = s / 4;
    if (s < 0 && s % 4 != 0) q = q - 1;
`endif
    return q[15:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mh_l[i] = 0;
      mh_r[i] = 0;
    end
    exp_ur = '0;
  endtask

  task automatic wait_stb();
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
    do begin
      @(negedge clk);
      n++;
      for (int i = 0; i < 4; i++) rdy_cnt[i] += int'(src_ready[i]);
    end while (sample_stb !== 1'b1 && n < 60);
    checks++;
    if (sample_stb !== 1'b1) begin
      errors++;
      $display("FAIL stb_timeout: sample_stb=%b after %0d cycles, required 1", sample_stb, n);
    end
  endtask

  task automatic sync();
    src_en = '0;
    wait_stb();
  endtask

  task automatic expect_frame(input string name);
    int sl, sr;
    sl = 0;
    sr = 0;
    for (int i = 0; i < 4; i++) begin
      if (src_en[i]) begin
        if (src_valid[i]) begin
          mh_l[i] = int'($signed(src_left[i*16 +: 16]));
          mh_r[i] = int'($signed(src_right[i*16 +: 16]));
        end else exp_ur[i] = 1'b1;
        sl += mh_l[i];
        sr += mh_r[i];
      end
    end
    wait_stb();
    checks++;
    if (left_chan !== mix(sl)) begin
      errors++;
      $display("FAIL %s left: got %h required %h", name, left_chan, mix(sl));
    end
    checks++;
    if (right_chan !== mix(sr)) begin
      errors++;
      $display("FAIL %s right: got %h required %h", name, right_chan, mix(sr));
    end
    checks++;
    if (underrun !== exp_ur) begin
      errors++;
      $display("FAIL %s underrun: got %b required %b", name, underrun, exp_ur);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdy_cnt[i] != int'(src_en[i] & src_valid[i])) begin
        errors++;
        $display("FAIL %s ready%0d pulses: got %0d required %0d", name, i, rdy_cnt[i], int'(src_en[i] & src_valid[i]));
      end
    end
  endtask

  task automatic run_frame(input string name, input logic [3:0] en, input logic [3:0] v, input logic [63:0] l, input logic [63:0] r);
    src_en    = en;
    src_valid = v;
    src_left  = l;
    src_right = r;
    expect_frame(name);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 5;
    if (left_chan !== 16'h0)  begin errors++; $display("FAIL reset left: got %h required 0000", left_chan); end
    if (right_chan !== 16'h0) begin errors++; $display("FAIL reset right: got %h required 0000", right_chan); end
    if (sample_stb !== 1'b0)  begin errors++; $display("FAIL reset stb: got %b required 0", sample_stb); end
    if (underrun !== 4'h0)    begin errors++; $display("FAIL reset underrun: got %b required 0000", underrun); end
    if (src_ready !== 4'h0)   begin errors++; $display("FAIL reset ready: got %b required 0000", src_ready); end
    reset_n = 1'b1;
    model_reset();
    sync();
  endtask

  task automatic test_mix_basic();
    run_frame("basic", 4'hF, 4'hF, {16'd10, 16'hFFCE, 16'd200, 16'd100}, {$urandom, $urandom});
    run_frame("basic_neg", 4'hF, 4'hF, {16'hFFF6, 16'd50, 16'hFF38, 16'hFF9C}, {16'd1, 16'd2, 16'd3, 16'hFFFF});
  endtask

  task automatic test_saturation();
    run_frame("sat_pos", 4'hF, 4'hF, {4{16'h7000}}, {4{16'h7FFF}});
    run_frame("sat_neg", 4'hF, 4'hF, {4{16'h9000}}, {4{16'h8000}});
  endtask

  task automatic test_enable();
    run_frame("enable", 4'b0101, 4'hF, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic test_underrun();
    run_frame("ur_prime", 4'hF, 4'hF, {$urandom, $urandom}, {$urandom, $urandom});
    run_frame("ur_drop", 4'hF, 4'b1011, {$urandom, $urandom}, {$urandom, $urandom});
    run_frame("ur_sticky", 4'hF, 4'hF, {$urandom, $urandom}, {$urandom, $urandom});
    src_en = '0;
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    exp_ur = '0;
    checks++;
    if (underrun !== 4'h0) begin
      errors++;
      $display("FAIL ur_clear: got %b required 0000", underrun);
    end
    sync();
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++)
      run_frame("random", 4'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic test_back_to_back();
    int prev;
    src_en = '0;
    clk_rate = 32'd96_000;
    repeat (3) wait_stb();
    prev = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_stb();
      checks++;
      if (cyc - prev != 6) begin
        errors++;
        $display("FAIL b2b period: got %0d cycles required 6", cyc - prev);
      end
      prev = cyc;
    end
    clk_rate = 32'd480_000;
    repeat (3) wait_stb();
  endtask

  task automatic test_reset_midscan();
    int n;
    run_frame("pre_reset", 4'hF, 4'hF, {$urandom, $urandom}, {$urandom, $urandom});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (src_ready[0] !== 1'b1 && n < 60);
    checks++;
    if (src_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL midscan_ready0: got %b required 1", src_ready[0]);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks += 5;
    if (left_chan !== 16'h0)  begin errors++; $display("FAIL midscan left: got %h required 0000", left_chan); end
    if (right_chan !== 16'h0) begin errors++; $display("FAIL midscan right: got %h required 0000", right_chan); end
    if (src_ready !== 4'h0)   begin errors++; $display("FAIL midscan ready: got %b required 0000", src_ready); end
    if (underrun !== 4'h0)    begin errors++; $display("FAIL midscan underrun: got %b required 0000", underrun); end
    if (sample_stb !== 1'b0)  begin errors++; $display("FAIL midscan stb: got %b required 0", sample_stb); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    src_left  = {$urandom, $urandom};
    src_right = {$urandom, $urandom};
    expect_frame("fresh");
  endtask

  initial begin
    reset_n      = 1'b0;
    clk_rate     = 32'd480_000;
    src_en       = '0;
    src_valid    = '0;
    src_left     = '0;
    src_right    = '0;
    underrun_clr = 1'b0;
    model_reset();
    test_reset();
    test_mix_basic();
    test_saturation();
    test_enable();
    test_underrun();
    test_random();
    test_back_to_back();
    test_reset_midscan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
